cordic_issue_ctrl: RTL and testbench
====================================

# cordic_issue_ctrl

Initiator-side sequencer that feeds single-precision angles into `accelerator_top` and collects the cosine results. It accepts float angles on a valid/ready stream, drives the accelerator's `start`/`x_ft` inputs one operation at a time, samples `y_ft` after a fixed latency, and buffers results in an output FIFO. It sits between a DMA or CPU-side stream and the folded CORDIC accelerator, replacing hand-timed `start` pulses.

## Interface
- `LATENCY`, 6: rising edges from the edge that samples `acc_start` high to the edge at which `acc_y_ft` is valid; range 1..255.
- `RES_DEPTH`, 4: result FIFO depth; must be a power of two, at least 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `clk_en` in 1: global enable; when 0, all state is frozen.
- `in_valid` in 1: angle available.
- `in_data` in 32: IEEE-754 single-precision angle.
- `in_ready` out 1: angle accepted on an edge where `in_valid` and `in_ready` are both 1.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out 32: FIFO head, the float result.
- `out_ready` in 1: pop on an edge where `out_valid` and `out_ready` are both 1.
- `acc_clk_en` out 1: combinational copy of `clk_en`.
- `acc_start` out 1: one-cycle start pulse to the accelerator.
- `acc_x_ft` out 32: registered angle to the accelerator.
- `acc_y_ft` in 32: accelerator float result.
- `busy` out 1: high when the state is not IDLE.
- `done_count` out 16: number of completed operations; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - `in_ready = clk_en & !fifo_full`.
  - On a handshake, latch `in_data` into `acc_x_ft` and go to ISSUE.
- **ISSUE:**
  - `acc_start = clk_en`. Lasts exactly one enabled cycle.
  - Load the wait counter with `LATENCY`, then go to WAIT.
- **WAIT:**
  - The counter decrements on each enabled edge.
  - On the edge where it reaches 0: write `acc_y_ft` into the FIFO, increment `done_count`, go to IDLE.
- **Outstanding operations:** at most one at a time.
  - FIFO space is checked at accept time, so a capture can never overflow the FIFO.
- **FIFO:**
  - Read/write pointers wrap modulo `RES_DEPTH`; occupancy count is `$clog2(RES_DEPTH)+1` bits.
  - Simultaneous push and pop leaves the count unchanged, and both pointers advance.
  - Pop when empty is impossible because `out_valid` is 0.
- **`out_data`:** equals the FIFO head when `out_valid` is 1; its value when `out_valid` is 0 is don't-care.
- **`clk_en` = 0:**
  - State, counter, FIFO and `done_count` hold.
  - `acc_start`, `in_ready` and `out_valid` are forced to 0.
  - An ISSUE interrupted by `clk_en` = 0 re-pulses `acc_start` when enable returns.
- **Reset (asynchronous, any state):**
  - State goes to IDLE; the in-flight operation is discarded; the FIFO is emptied.
  - Outputs: `acc_start`=0, `acc_x_ft`=0, `in_ready`=0 while asserted, `out_valid`=0, `busy`=0, `done_count`=0, `out_data`=0.

## Timing
- Input handshake at edge H:
  - `acc_start` is high during cycle H..H+1 and is sampled at edge H+1.
  - Capture occurs at edge H+1+LATENCY.
  - `out_valid` rises in the following cycle if the FIFO was empty.
- `in_ready` rises again at edge H+2+LATENCY (FIFO not full). Sustained throughput is one operation per `LATENCY`+2 cycles.
- `in_ready`, `out_valid` and `busy` are registered state decoded combinationally with `clk_en`. There is no combinational path from `in_valid` or `out_ready` to any output.
- Release of `reset` is taken synchronously by the design; the first handshake is possible at the first edge after release.

## Test plan
Stub accelerator for all scenarios: `y_ft = x_ft + 1`, valid `LATENCY` edges after `start` is sampled.
- **Single operation:** LATENCY=6, send `0x3C23D70A` (0.01) with `out_ready`=1 → `acc_start` is one cycle high at H+1; `out_data=0x3C23D70B` with `out_valid` the cycle after edge H+7; `done_count`=1; `busy` low from H+7.
- **Back-to-back:** `in_valid` held with 8 angles 0..7 and `out_ready`=1 → accepts spaced exactly 8 cycles apart; outputs 1..8 in order; `done_count`=8.
- **FIFO full:** `out_ready`=0, RES_DEPTH=4, offer 6 angles → 4 accepted, then `in_ready` stays 0. Raising `out_ready` drains 4 and resumes the remaining 2; no loss or duplication.
- **Simultaneous push/pop:** FIFO holding 1 entry, `out_ready`=1 on the capture edge → count stays 1 and order is preserved.
- **`clk_en` gap:** drop `clk_en` for 5 cycles during ISSUE and during WAIT → `acc_start` is re-pulsed once after resume; the capture edge shifts by exactly 5; the result is correct.
- **Reset mid-WAIT** (counter=3, FIFO holding 2) → all outputs at reset values immediately. After release no stale result appears, and a new operation completes normally.

Source files
------------

// File: rtl/cordic_issue_ctrl.sv
// Issue sequencer for the folded CORDIC accelerator: accepts float angles, issues one
// operation at a time, captures y_ft after a fixed latency and buffers results in a FIFO.
module cordic_issue_ctrl #(
  parameter int unsigned LATENCY   = 6,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        acc_clk_en,
  output logic        acc_start,
  output logic [31:0] acc_x_ft,
  input  logic [31:0] acc_y_ft,
  output logic        busy,
  output logic [15:0] done_count
);

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned PW = $clog2(RES_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_cnt;
  logic [LW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   r_x_ft;
  logic [DW-1:0]   w_x_ft_nxt;
  logic [15:0]     r_done;
  logic            w_push;
  logic            w_pop;
  logic            w_full;

  logic [DW-1:0]   r_mem [RES_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Handshake and status decode; reset gates in_ready so nothing is accepted while held.
  assign w_full     = (r_count == CW'(RES_DEPTH));
  assign in_ready   = clk_en & reset & (r_state == S_IDLE) & ~w_full;
  assign out_valid  = clk_en & (r_count != '0);
  assign w_pop      = out_valid & out_ready;
  assign out_data   = r_mem[r_rd_ptr];
  assign acc_clk_en = clk_en;
  assign acc_start  = clk_en & (r_state == S_ISSUE);
  assign acc_x_ft   = r_x_ft;
  assign busy       = (r_state != S_IDLE);
  assign done_count = r_done;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, wait counter and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_ft_nxt  = r_x_ft;
    w_push      = 1'b0;
    if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            w_x_ft_nxt  = in_data;
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_cnt_nxt   = LW'(LATENCY);
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == LW'(1)) begin
            w_cnt_nxt   = '0;
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - LW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_x_ft <= '0;
      r_done <= '0;
    end else if (clk_en) begin
      r_cnt  <= w_cnt_nxt;
      r_x_ft <= w_x_ft_nxt;
      if (w_push) begin
        r_done <= r_done + 16'd1;
      end
    end
  end

  // Result FIFO; space was reserved at accept time so a push never finds it full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clk_en) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= acc_y_ft;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_issue_ctrl.sv
// Bench for cordic_issue_ctrl: stub accelerator (y = x + 1 after LATENCY), transaction-level
// reference model checked every cycle, plus directed timing sequences and random traffic.
module tb_cordic_issue_ctrl;

  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        acc_clk_en;
  logic        acc_start;
  logic [31:0] acc_x_ft;
  logic [31:0] acc_y_ft;
  logic        busy;
  logic [15:0] done_count;

  always #5 clk = ~clk;

  cordic_issue_ctrl #(.LATENCY(LAT), .RES_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .acc_clk_en(acc_clk_en), .acc_start(acc_start), .acc_x_ft(acc_x_ft),
    .acc_y_ft(acc_y_ft), .busy(busy), .done_count(done_count)
  );

  // Stub accelerator: result presented only in the cycle before it is due
  int          stub_cnt;
  logic [31:0] stub_val;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stub_cnt <= -1;
      stub_val <= '0;
    end else if (clk_en) begin
      if (acc_start) begin
        stub_cnt <= int'(LAT) - 1;
        stub_val <= acc_x_ft + 32'd1;
      end else if (stub_cnt >= 0) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end
  assign acc_y_ft = (stub_cnt == 0) ? stub_val : 32'hDEAD_BEEF;

  // Reference model: one job in flight, counted in enabled edges; results in a queue
  bit          m_busy;
  int          m_edges;
  logic [31:0] m_x;
  logic [31:0] m_q[$];
  logic [15:0] m_done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic        smp_ov, smp_st, smp_ir;
  logic [31:0] smp_od;
  int          smp_cyc;
  bit          last_hs, last_pop;
  logic [31:0] last_pop_d;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_clear();
    m_busy = 0; m_edges = 0; m_x = '0; m_q.delete(); m_done = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_acc_start"}, 32'(acc_start), 32'd0);
    chk({tag, "_acc_x_ft"}, acc_x_ft, 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_count"}, 32'(done_count), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
  endtask

  // One clock: compare against model at negedge, then advance model on the edge
  task automatic cycle();
    logic e_ir, e_ov, e_st, hs, pop;
    logic [31:0] hs_d, pop_d;
    @(negedge clk);
    e_ir = clk_en && reset && !m_busy && (m_q.size() < int'(DEPTH));
    e_ov = clk_en && (m_q.size() != 0);
    e_st = clk_en && m_busy && (m_edges == 0);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("acc_start", 32'(acc_start), 32'(e_st));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done_count", 32'(done_count), 32'(m_done));
    chk("acc_x_ft", acc_x_ft, m_x);
    chk("acc_clk_en", 32'(acc_clk_en), 32'(clk_en));
    if (e_ov) chk("out_data", out_data, m_q[0]);
    smp_ov = out_valid; smp_od = out_data; smp_st = acc_start; smp_ir = in_ready; smp_cyc = cyc;
    hs = e_ir && in_valid; pop = e_ov && out_ready; hs_d = in_data; pop_d = out_data;
    @(posedge clk);
    cyc++;
    if (reset && clk_en) begin
      if (m_busy) begin
        m_edges++;
        if (m_edges == int'(LAT) + 1) begin
          m_q.push_back(m_x + 32'd1);
          m_done = m_done + 16'd1;
          m_busy = 0;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (hs) begin m_busy = 1; m_edges = 0; m_x = hs_d; end
    end else begin
      hs = 0; pop = 0;
    end
    last_hs = hs; last_pop = pop; last_pop_d = pop_d;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input string name, input logic [31:0] x, output int h);
    bit got = 0;
    in_valid = 1; in_data = x; h = -1;
    for (int b = 0; b < 40; b++) begin
      cycle();
      if (last_hs) begin got = 1; h = cyc; break; end
    end
    in_valid = 0;
    chk({name, "_accept"}, 32'(got), 32'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, ii, oi, st_cnt, st_cyc, ov_cyc, nb_cyc;
    logic [31:0] ov_d;
    int hs_cyc[10];

    for (int i = 0; i < 8; i++) tbl[i] = '{32'(i), 32'(i + 1)};
    tbl[8] = '{32'h7F7F_FFFF, 32'h7F80_0000};
    tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0000};

    reset = 0; clk_en = 1; in_valid = 0; in_data = '0; out_ready = 0;
    model_clear();
    #1 chk_reset("por");
    run(2);
    reset = 1;

    // Single operation with exact timing
    out_ready = 1;
    send("single", 32'h3C23_D70A, h);
    st_cnt = 0; st_cyc = -1; ov_cyc = -1; nb_cyc = -1; ov_d = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (smp_st) begin st_cnt++; if (st_cyc < 0) st_cyc = smp_cyc; end
      if (smp_ov && ov_cyc < 0) begin ov_cyc = smp_cyc; ov_d = smp_od; end
      if (!busy && nb_cyc < 0) nb_cyc = cyc;
    end
    chk("single_start_count", 32'(st_cnt), 32'd1);
    chk("single_start_cycle", 32'(st_cyc), 32'(h));
    chk("single_out_cycle", 32'(ov_cyc), 32'(h + 7));
    chk("single_out_data", ov_d, 32'h3C23_D70B);
    chk("single_idle_edge", 32'(nb_cyc), 32'(h + 7));
    chk("single_done", 32'(done_count), 32'd1);

    // Table-driven back-to-back stream
    ii = 0; oi = 0;
    for (int b = 0; b < 200 && oi < 10; b++) begin
      in_valid = (ii < 10);
      if (ii < 10) in_data = tbl[ii].x;
      cycle();
      if (last_hs && ii < 10) begin hs_cyc[ii] = cyc; ii++; end
      if (last_pop && oi < 10) begin chk("b2b_data", last_pop_d, tbl[oi].y); oi++; end
    end
    in_valid = 0;
    chk("b2b_out_count", 32'(oi), 32'd10);
    for (int i = 1; i < 10; i++) chk("b2b_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(LAT + 2));
    chk("b2b_done", 32'(done_count), 32'd11);

    // FIFO full back-pressure
    out_ready = 0; ii = 0; oi = 0;
    for (int b = 0; b < 64; b++) begin
      in_valid = (ii < 6); in_data = 32'h100 + 32'(ii);
      cycle();
      if (last_hs) ii++;
    end
    chk("full_accepted", 32'(ii), 32'd4);
    chk("full_in_ready", 32'(smp_ir), 32'd0);
    chk("full_out_valid", 32'(smp_ov), 32'd1);
    out_ready = 1;
    for (int b = 0; b < 120 && oi < 6; b++) begin
      in_valid = (ii < 6); in_data = 32'h100 + 32'(ii);
      cycle();
      if (last_hs) ii++;
      if (last_pop) begin chk("full_drain_data", last_pop_d, 32'h101 + 32'(oi)); oi++; end
    end
    in_valid = 0;
    chk("full_drain_count", 32'(oi), 32'd6);
    run(4);
    chk("full_done", 32'(done_count), 32'd17);

    // Push and pop on the same edge with one entry held
    out_ready = 0;
    send("pp_a", 32'h200, h);
    run(9);
    send("pp_b", 32'h300, h);
    while (cyc < h + 6) cycle();
    out_ready = 1;
    cycle();
    chk("pp_head_a_valid", 32'(smp_ov), 32'd1);
    chk("pp_head_a", smp_od, 32'h201);
    out_ready = 0;
    cycle();
    chk("pp_head_b_valid", 32'(smp_ov), 32'd1);
    chk("pp_head_b", smp_od, 32'h301);
    out_ready = 1;
    cycle();
    out_ready = 0;
    cycle();
    chk("pp_empty", 32'(smp_ov), 32'd0);

    // clk_en gaps during ISSUE and during WAIT
    out_ready = 1;
    send("gap", 32'h400, h);
    st_cnt = 0; ov_cyc = -1; ov_d = '0;
    for (int ph = 0; ph < 4; ph++) begin
      clk_en = (ph % 2 == 1);
      for (int i = 0; i < ((ph == 0 || ph == 2) ? 5 : (ph == 1 ? 3 : 8)); i++) begin
        cycle();
        if (smp_st) st_cnt++;
        if (smp_ov && ov_cyc < 0) begin ov_cyc = smp_cyc; ov_d = smp_od; end
      end
    end
    clk_en = 1;
    chk("gap_start_count", 32'(st_cnt), 32'd1);
    chk("gap_out_cycle", 32'(ov_cyc), 32'(h + 17));
    chk("gap_out_data", ov_d, 32'h401);

    // Asynchronous reset mid-WAIT with two results buffered
    out_ready = 0;
    send("rst_a", 32'h500, h); run(9);
    send("rst_b", 32'h600, h); run(9);
    send("rst_c", 32'h700, h);
    while (cyc < h + 4) cycle();
    reset = 0;
    #1 chk_reset("midwait");
    model_clear();
    run(2);
    reset = 1;
    out_ready = 1; ov_cyc = 0;
    for (int i = 0; i < 12; i++) begin cycle(); if (smp_ov) ov_cyc++; end
    chk("rst_no_stale", 32'(ov_cyc), 32'd0);
    send("rst_new", 32'h800, h);
    oi = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (last_pop) begin chk("rst_new_data", last_pop_d, 32'h801); oi++; end
    end
    chk("rst_new_count", 32'(oi), 32'd1);
    chk("rst_new_done", 32'(done_count), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      clk_en    = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      in_data   = $urandom;
      out_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
    end
    clk_en = 1; in_valid = 0; out_ready = 1;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
